// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control FSM: sequences FETCH/DECODE/execute/writeback with a memory ready handshake.
// Optional build macro ILLEGAL_TRAP_EN: unsupported opcodes trap (sticky illegal_instr) instead of acting as NOPs.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC and IR load when memory is ready
// DECODE   | compute branch target OldPC+imm, dispatch on opcode
// MEMADR   | rs1+imm address for lw/sw
// MEMREAD  | data read at ALUOut, held until memory is ready
// MEMWB    | load data written to rd
// MEMWRITE | data write at ALUOut, held until memory is ready
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// JAL      | PC <= jump target, OldPC+4 computed for rd
// ALUWB    | ALUOut written to rd
// BEQ      | rs1-rs2 compare, PC <= target when zero
// TRAP     | unsupported opcode, frozen until reset
module multicycle_controller #(
    parameter int unsigned STATE_W   = 4,
    parameter bit          MEM_FIXED = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       PCWrite_o,
    output logic       AdrSrc_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] ResultSrc_o,
    output logic [1:0] ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic       RegWrite_o,
    output logic [1:0] ImmSrc_o,
    output logic [2:0] ALUControl_o,
    output logic       instr_done_o,
    output logic       illegal_instr_o
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BEQ, S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic       mem_rdy;
    logic       op_ok;
    logic [1:0] alu_op;

    assign mem_rdy = MEM_FIXED ? 1'b1 : mem_ready_i;

    always_comb begin
        case (op_i)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_ok = 1'b1;
            default:                                  op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    assign illegal_d = illegal_q | ((state_q == S_DECODE) && !op_ok);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) illegal_q <= 1'b0;
        else          illegal_q <= illegal_d;
    end

    assign illegal_instr_o = illegal_q;
`else
    assign illegal_instr_o = 1'b0;
`endif

    always_comb begin
        mem_req_o    = 1'b0;
        PCWrite_o    = 1'b0;
        AdrSrc_o     = 1'b0;
        MemWrite_o   = 1'b0;
        IRWrite_o    = 1'b0;
        ResultSrc_o  = 2'b00;
        ALUSrcA_o    = 2'b00;
        ALUSrcB_o    = 2'b00;
        RegWrite_o   = 1'b0;
        instr_done_o = 1'b0;
        alu_op       = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                ALUSrcB_o   = 2'b10;
                ResultSrc_o = 2'b10;
                IRWrite_o   = mem_rdy;
                PCWrite_o   = mem_rdy;
            end
            S_DECODE: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                instr_done_o = !op_ok;
`endif
            end
            S_MEMADR: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                AdrSrc_o  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc_o  = 2'b01;
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_o    = 1'b1;
                AdrSrc_o     = 1'b1;
                MemWrite_o   = 1'b1;
                instr_done_o = mem_rdy;
            end
            S_EXECR: begin
                ALUSrcA_o = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA_o = 2'b10;
                ALUSrcB_o = 2'b01;
                alu_op    = 2'b10;
            end
            S_JAL: begin
                ALUSrcA_o = 2'b01;
                ALUSrcB_o = 2'b10;
                PCWrite_o = 1'b1;
            end
            S_ALUWB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA_o    = 2'b10;
                alu_op       = 2'b01;
                PCWrite_o    = zero_i;
                instr_done_o = 1'b1;
            end
            default: ;
        endcase
        // reset kills every strobe even though the state already reads FETCH
        if (!rst_n_i) begin
            mem_req_o    = 1'b0;
            PCWrite_o    = 1'b0;
            MemWrite_o   = 1'b0;
            IRWrite_o    = 1'b0;
            RegWrite_o   = 1'b0;
            instr_done_o = 1'b0;
        end
    end

    always_comb begin
        case (alu_op)
            2'b01: ALUControl_o = 3'b001;
            2'b10: begin
                case (funct3_i)
                    3'b000:  ALUControl_o = (op_i[5] & funct7b5_i) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl_o = 3'b101;
                    3'b110:  ALUControl_o = 3'b011;
                    3'b111:  ALUControl_o = 3'b010;
                    default: ALUControl_o = 3'b000;
                endcase
            end
            default: ALUControl_o = 3'b000;
        endcase
    end

    always_comb begin
        case (op_i)
            OP_SW:   ImmSrc_o = 2'b01;
            OP_BEQ:  ImmSrc_o = 2'b10;
            OP_JAL:  ImmSrc_o = 2'b11;
            default: ImmSrc_o = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected outputs built per instruction class,
// plus literal latency / ALUControl / PCWrite pins. Honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       mem_req, pcw, adr, mw, irw;
        logic [1:0] rs, a, b;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       done, ill;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int   checks = 0, failures = 0;
    int   cyc = 0, last_lat = 0, done_cnt = 0;
    logic ill_model = 1'b0;
    exp_t exp_q[$];
    exp_t last_snap, key_snap;

    multicycle_controller dut (
        .clk_i(clk), .rst_n_i(rst_n), .op_i(op), .funct3_i(funct3), .funct7b5_i(funct7b5),
        .zero_i(zero), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .PCWrite_o(PCWrite),
        .AdrSrc_o(AdrSrc), .MemWrite_o(MemWrite), .IRWrite_o(IRWrite), .ResultSrc_o(ResultSrc),
        .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .RegWrite_o(RegWrite), .ImmSrc_o(ImmSrc),
        .ALUControl_o(ALUControl), .instr_done_o(instr_done), .illegal_instr_o(illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic exp_t dut_vec();
        return {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, instr_done, illegal_instr};
    endfunction

    function automatic logic [1:0] imm_model(logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
        if (o == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // ALU operation the instruction itself asks for: sub only for R-type funct7b5
    function automatic logic [2:0] alu_for(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t fetch_e(logic mr);
        exp_t e = '0;
        e.mem_req = 1'b1; e.b = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        exp_t e, act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = dut_vec();
                chk("cycle_outputs", 32'(act), 32'(e));
            end
            if (!rst_n) cyc = 0;
            else begin
                cyc++;
                if (instr_done) begin
                    last_lat = cyc;
                    cyc = 0;
                    done_cnt++;
                end
            end
        end
    endtask

    task automatic push_step(input logic mr, input exp_t e_in);
        exp_t e = e_in;
        mem_ready = mr;
        e.imm = imm_model(op);
        e.ill = ill_model;
        exp_q.push_back(e);
        #1 last_snap = dut_vec();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t e = fetch_e(1'b0);
        e.mem_req = 1'b0;
        rst_n = 1'b0;
        ill_model = 1'b0;
        repeat (n) push_step(1'b1, e);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                             input int fst, input int mst, input int exp_lat, input bit abort_mw);
        exp_t e;
        int   d0 = done_cnt;
        bit   sup = (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_JAL || o == OP_BEQ);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        repeat (fst) push_step(1'b0, fetch_e(1'b0));
        push_step(1'b1, fetch_e(1'b1));
        e = '0; e.a = 2'b01; e.b = 2'b01; e.done = !sup && !TRAP_EN;
        push_step(1'b1, e);
        if (o == OP_LW || o == OP_SW) begin
            e = '0; e.a = 2'b10; e.b = 2'b01;
            push_step(1'b1, e);
            e = '0; e.mem_req = 1'b1; e.adr = 1'b1; e.mw = (o == OP_SW);
            repeat (mst) push_step(1'b0, e);
            if (!abort_mw) begin
                e.done = (o == OP_SW);
                push_step(1'b1, e);
                key_snap = last_snap;
                if (o == OP_LW) begin
                    e = '0; e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1;
                    push_step(1'b1, e);
                    key_snap = last_snap;
                end
            end
        end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
            e = '0;
            if (o == OP_JAL) begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
            else begin e.a = 2'b10; e.b = (o == OP_I) ? 2'b01 : 2'b00; e.alu = alu_for(o, f3, f7); end
            push_step(1'b1, e);
            key_snap = last_snap;
            e = '0; e.rw = 1'b1; e.done = 1'b1;
            push_step(1'b1, e);
        end else if (o == OP_BEQ) begin
            e = '0; e.a = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1'b1;
            push_step(1'b1, e);
            key_snap = last_snap;
        end else if (TRAP_EN) begin
            ill_model = 1'b1;
            repeat (4) push_step(1'b1, exp_t'('0));
        end
        if (exp_lat > 0) begin
            chk("done_count", 32'(done_cnt - d0), 32'd1);
            chk("latency", 32'(last_lat), 32'(exp_lat));
        end else begin
            chk("no_done", 32'(done_cnt - d0), 32'd0);
        end
    endtask

    initial begin
        fork
            compare_loop();
        join_none
        @(posedge clk);
        #1;
        do_reset(2);
        chk("reset_ill", 32'(illegal_instr), 32'd0);

        run_instr(OP_R, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("add_alu", 32'(key_snap.alu), 32'h0);
        chk("add_rw_exec", 32'(key_snap.rw), 32'h0);
        run_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0, 4, 1'b0);
        chk("sub_alu", 32'(key_snap.alu), 32'h1);
        run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("slt_alu", 32'(key_snap.alu), 32'h5);
        run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("and_alu", 32'(key_snap.alu), 32'h2);
        run_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0, 4, 1'b0);
        chk("addi_alu", 32'(key_snap.alu), 32'h0);
        run_instr(OP_I, 3'b110, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("ori_alu", 32'(key_snap.alu), 32'h3);

        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0, 5, 1'b0);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3, 8, 1'b0);
        chk("lw_memwb_rw", 32'(key_snap.rw), 32'h1);
        run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 2, 0, 7, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2, 6, 1'b0);
        chk("sw_mw", 32'(key_snap.mw), 32'h1);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("jal_pcw", 32'(key_snap.pcw), 32'h1);

        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 3, 1'b0);
        chk("beq_taken_pcw", 32'(key_snap.pcw), 32'h1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 3, 1'b0);
        chk("beq_not_pcw", 32'(key_snap.pcw), 32'h0);
        chk("beq_alu", 32'(key_snap.alu), 32'h1);

        run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2, 0, 1'b1);
        chk("mw_before_rst", 32'(MemWrite), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mw_in_rst", 32'(MemWrite), 32'h0);
        chk("req_in_rst", 32'(mem_req), 32'h0);
        do_reset(2);
        run_instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("or_after_rst_alu", 32'(key_snap.alu), 32'h3);

        run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0, TRAP_EN ? 0 : 2, 1'b0);
        chk("illegal_flag", 32'(illegal_instr), 32'(TRAP_EN));
        do_reset(2);
        chk("illegal_cleared", 32'(illegal_instr), 32'h0);
        run_instr(OP_I, 3'b111, 1'b0, 1'b0, 0, 0, 4, 1'b0);
        chk("andi_alu", 32'(key_snap.alu), 32'h2);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
